// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared state encoding and parity mode constants for the parity receiver
package parity_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/parity_calc.sv
// rtl/parity_calc.sv - combinational expected-parity bit over a data word
module parity_calc
  import parity_pkg::*;
#(
  parameter int DATA_W   = 3,
  parameter int PAR_MODE = PAR_EVEN
) (
  input  logic [DATA_W-1:0] data,
  output logic              par
);

  assign par = (PAR_MODE == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/parity_rx_check.sv
// rtl/parity_rx_check.sv - serial frame receiver with parity/framing check and saturating error count
module parity_rx_check
  import parity_pkg::*;
#(
  parameter int DATA_W   = 3,
  parameter int PAR_MODE = PAR_EVEN,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_valid,
  input  logic              ser_bit,
  input  logic              clear_cnt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              par_err,
  output logic              frm_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int                IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   shreg;
  logic                rx_par;
  logic                exp_par;

  parity_calc #(
    .DATA_W   (DATA_W),
    .PAR_MODE (PAR_MODE)
  ) u_parity_calc (
    .data (shreg),
    .par  (exp_par)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DONE is the only state that advances without ser_valid
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (ser_valid && !ser_bit)          state_nxt = ST_DATA;
      ST_DATA:   if (ser_valid && (idx == LAST_IDX)) state_nxt = ST_PARITY;
      ST_PARITY: if (ser_valid)                      state_nxt = ST_STOP;
      ST_STOP:   if (ser_valid)                      state_nxt = ST_DONE;
      ST_DONE:                                       state_nxt = ST_IDLE;
      default:                                       state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      shreg     <= '0;
      rx_par    <= 1'b0;
      out_data  <= '0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == ST_DONE);
      if (ser_valid) begin
        case (state)
          ST_IDLE: begin
            if (!ser_bit) idx <= '0;
          end
          ST_DATA: begin
            shreg[idx] <= ser_bit;
            if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
          end
          ST_PARITY: begin
            rx_par <= ser_bit;
          end
          ST_STOP: begin
            // parity is judged even when the stop bit is bad
            out_data <= shreg;
            par_err  <= (rx_par != exp_par);
            frm_err  <= ~ser_bit;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clear_cnt) begin
      err_cnt <= '0;
    end else if ((state == ST_DONE) && (par_err || frm_err) && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_parity_rx_check.sv
// tb/tb_parity_rx_check.sv - directed self-checking bench for parity_rx_check
module tb_parity_rx_check;

  logic       clk = 1'b0;
  logic       rst_n, ser_valid, ser_bit, clear_cnt;
  logic       ov0, pe0, fe0, bz0;
  logic [2:0] od0;
  logic [7:0] ec0;
  logic       ov1, pe1, fe1, bz1;
  logic [2:0] od1;
  logic [7:0] ec1;
  logic       ov2, pe2, fe2, bz2;
  logic [2:0] od2;
  logic [1:0] ec2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int np0 = 0, np1 = 0, np2 = 0;
  int lc0 = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // even mode, 8-bit counter
  parity_rx_check #(.DATA_W(3), .PAR_MODE(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .ser_valid(ser_valid), .ser_bit(ser_bit), .clear_cnt(clear_cnt),
    .out_valid(ov0), .out_data(od0), .par_err(pe0), .frm_err(fe0), .err_cnt(ec0), .busy(bz0));
  // odd mode
  parity_rx_check #(.DATA_W(3), .PAR_MODE(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .ser_valid(ser_valid), .ser_bit(ser_bit), .clear_cnt(clear_cnt),
    .out_valid(ov1), .out_data(od1), .par_err(pe1), .frm_err(fe1), .err_cnt(ec1), .busy(bz1));
  // even mode, 2-bit counter for saturation
  parity_rx_check #(.DATA_W(3), .PAR_MODE(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ser_valid(ser_valid), .ser_bit(ser_bit), .clear_cnt(clear_cnt),
    .out_valid(ov2), .out_data(od2), .par_err(pe2), .frm_err(fe2), .err_cnt(ec2), .busy(bz2));

  always @(negedge clk) begin
    if (ov0) begin
      np0 <= np0 + 1;
      lc0 <= cyc;
    end
    if (ov1) np1 <= np1 + 1;
    if (ov2) np2 <= np2 + 1;
  end

  task automatic step(input logic v, input logic b);
    ser_valid = v;
    ser_bit   = b;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [2:0] d, input logic p, input logic s, input bit gap,
                            input logic clr, input int idle, output int stop_cyc);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, d[i]);
      if (gap && i == 0) begin
        for (int g = 0; g < 3; g++) step(1'b0, 1'($urandom_range(0, 1)));
      end
    end
    step(1'b1, p);
    stop_cyc = cyc;
    step(1'b1, s);
    clear_cnt = clr;
    step(1'b1, 1'b1);
    clear_cnt = 1'b0;
    for (int i = 1; i < idle; i++) step(1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ser_valid = 1'b0; ser_bit = 1'b1; clear_cnt = 1'b0;
    @(negedge clk);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    rst_n = 1'b1;
    checks++; if (ov0 !== 1'b0)    begin errors++; $display("FAIL reset_out_valid got %b want 0", ov0); end
    checks++; if (od0 !== 3'b000)  begin errors++; $display("FAIL reset_out_data got %b want 000", od0); end
    checks++; if (pe0 !== 1'b0)    begin errors++; $display("FAIL reset_par_err got %b want 0", pe0); end
    checks++; if (fe0 !== 1'b0)    begin errors++; $display("FAIL reset_frm_err got %b want 0", fe0); end
    checks++; if (ec0 !== 8'd0)    begin errors++; $display("FAIL reset_err_cnt got %0d want 0", ec0); end
    checks++; if (bz0 !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", bz0); end
  endtask

  task automatic test_basic();
    int sc, n;
    n = np0;
    send_frame(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 3, sc);
    checks++; if (np0 - n !== 1)   begin errors++; $display("FAIL basic_pulses got %0d want 1", np0 - n); end
    checks++; if (lc0 !== sc + 2)  begin errors++; $display("FAIL basic_latency got cycle %0d want %0d", lc0, sc + 2); end
    checks++; if (od0 !== 3'b101)  begin errors++; $display("FAIL basic_data got %b want 101", od0); end
    checks++; if (pe0 !== 1'b0)    begin errors++; $display("FAIL basic_par_err got %b want 0", pe0); end
    checks++; if (fe0 !== 1'b0)    begin errors++; $display("FAIL basic_frm_err got %b want 0", fe0); end
    checks++; if (ec0 !== 8'd0)    begin errors++; $display("FAIL basic_err_cnt got %0d want 0", ec0); end
  endtask

  task automatic test_par_err();
    int sc;
    send_frame(3'b101, 1'b1, 1'b1, 1'b0, 1'b0, 3, sc);
    checks++; if (pe0 !== 1'b1)    begin errors++; $display("FAIL perr_par_err got %b want 1", pe0); end
    checks++; if (fe0 !== 1'b0)    begin errors++; $display("FAIL perr_frm_err got %b want 0", fe0); end
    checks++; if (ec0 !== 8'd1)    begin errors++; $display("FAIL perr_err_cnt got %0d want 1", ec0); end
    send_frame(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 3, sc);
    checks++; if (pe0 !== 1'b0)    begin errors++; $display("FAIL perr_good_par_err got %b want 0", pe0); end
    checks++; if (ec0 !== 8'd1)    begin errors++; $display("FAIL perr_good_err_cnt got %0d want 1", ec0); end
  endtask

  task automatic test_odd_mode();
    int sc;
    send_frame(3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 3, sc);
    checks++; if (pe1 !== 1'b0)    begin errors++; $display("FAIL odd_000_par_err got %b want 0", pe1); end
    checks++; if (od1 !== 3'b000)  begin errors++; $display("FAIL odd_000_data got %b want 000", od1); end
    send_frame(3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 3, sc);
    checks++; if (pe1 !== 1'b1)    begin errors++; $display("FAIL odd_111_par_err got %b want 1", pe1); end
    // same frames through the even-mode unit: 000/p1 is bad, 111/p1 is good
    checks++; if (ec0 !== 8'd2)    begin errors++; $display("FAIL even_side_err_cnt got %0d want 2", ec0); end
  endtask

  task automatic test_frm_err();
    int sc, n;
    send_frame(3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 3, sc);
    checks++; if (fe0 !== 1'b1)    begin errors++; $display("FAIL frm_frm_err got %b want 1", fe0); end
    checks++; if (pe0 !== 1'b0)    begin errors++; $display("FAIL frm_par_err got %b want 0", pe0); end
    checks++; if (ec0 !== 8'd3)    begin errors++; $display("FAIL frm_err_cnt got %0d want 3", ec0); end
    n = np0;
    send_frame(3'b110, 1'b0, 1'b1, 1'b1, 1'b0, 3, sc);
    checks++; if (np0 - n !== 1)   begin errors++; $display("FAIL gap_pulses got %0d want 1", np0 - n); end
    checks++; if (lc0 !== sc + 2)  begin errors++; $display("FAIL gap_latency got cycle %0d want %0d", lc0, sc + 2); end
    checks++; if (od0 !== 3'b110)  begin errors++; $display("FAIL gap_data got %b want 110", od0); end
    checks++; if (pe0 !== 1'b0 || fe0 !== 1'b0)
      begin errors++; $display("FAIL gap_flags got par=%b frm=%b want 0/0", pe0, fe0); end
    checks++; if (ec0 !== 8'd3)    begin errors++; $display("FAIL gap_err_cnt got %0d want 3", ec0); end
  endtask

  task automatic test_reset_mid_frame();
    int sc, n;
    n = np0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++; if (bz0 !== 1'b1)    begin errors++; $display("FAIL midrst_busy_before got %b want 1", bz0); end
    rst_n = 1'b0;
    step(1'b1, 1'b1);
    rst_n = 1'b1;
    checks++; if (bz0 !== 1'b0)    begin errors++; $display("FAIL midrst_busy got %b want 0", bz0); end
    checks++; if (ec0 !== 8'd0)    begin errors++; $display("FAIL midrst_err_cnt got %0d want 0", ec0); end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    checks++; if (np0 - n !== 0)   begin errors++; $display("FAIL midrst_pulses got %0d want 0", np0 - n); end
    send_frame(3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 3, sc);
    checks++; if (od0 !== 3'b011)  begin errors++; $display("FAIL midrst_next_data got %b want 011", od0); end
    checks++; if (pe0 !== 1'b0 || fe0 !== 1'b0 || ec0 !== 8'd0)
      begin errors++; $display("FAIL midrst_next_flags got par=%b frm=%b cnt=%0d want 0/0/0", pe0, fe0, ec0); end
  endtask

  task automatic test_back_to_back();
    int sca, scb, n;
    n = np0;
    send_frame(3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1, sca);
    send_frame(3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 3, scb);
    checks++; if (np0 - n !== 2)   begin errors++; $display("FAIL b2b_pulses got %0d want 2", np0 - n); end
    checks++; if (lc0 !== scb + 2) begin errors++; $display("FAIL b2b_latency got cycle %0d want %0d", lc0, scb + 2); end
    checks++; if (od0 !== 3'b110)  begin errors++; $display("FAIL b2b_data got %b want 110", od0); end
    checks++; if (pe0 !== 1'b0 || ec0 !== 8'd0)
      begin errors++; $display("FAIL b2b_flags got par=%b cnt=%0d want 0/0", pe0, ec0); end
  endtask

  task automatic test_saturate();
    int sc;
    for (int i = 0; i < 2; i++) send_frame(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 3, sc);
    checks++; if (ec2 !== 2'd2)    begin errors++; $display("FAIL sat_two got %0d want 2", ec2); end
    for (int i = 0; i < 3; i++) send_frame(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 3, sc);
    checks++; if (ec2 !== 2'd3)    begin errors++; $display("FAIL sat_five got %0d want 3", ec2); end
    checks++; if (ec0 !== 8'd5)    begin errors++; $display("FAIL sat_wide got %0d want 5", ec0); end
    send_frame(3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 3, sc);
    checks++; if (pe2 !== 1'b1)    begin errors++; $display("FAIL clr_par_err got %b want 1", pe2); end
    checks++; if (ec2 !== 2'd0)    begin errors++; $display("FAIL clr_narrow got %0d want 0", ec2); end
    checks++; if (ec0 !== 8'd0)    begin errors++; $display("FAIL clr_wide got %0d want 0", ec0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_par_err();
    test_odd_mode();
    test_frm_err();
    test_reset_mid_frame();
    test_back_to_back();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
